fifo_drain_fsm: RTL
===================

Name: fifo_drain_fsm

Overview:
Read-side controller for the 8-bit fifo_fsm buffer. It watches the FIFO's empty flag and issues single-cycle rd_en pulses. It captures each popped word and presents it downstream on a valid/ready handshake, holding it stable under backpressure. It sits between fifo_fsm and any consumer, so consumers never drive rd_en directly.

Parameters:
DATA_WIDTH, 8, width of FIFO data and downstream data
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately; released synchronously by the user
drain_en  input  1  1 = allowed to start new FIFO reads; 0 = finish any in-flight word, start no new read
fifo_empty  input  1  empty flag from fifo_fsm
fifo_data  input  DATA_WIDTH  data_out from fifo_fsm
fifo_rd_en  output  1  read strobe to fifo_fsm
out_data  output  DATA_WIDTH  word presented downstream
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts out_data when out_valid=1
word_count  output  CNT_WIDTH  number of words accepted downstream since reset
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fifo_rd_en=0, out_valid=0, out_data=0, word_count=0, busy=0. Any in-flight word is discarded. Nothing is re-read after reset releases.
- FIFO timing contract: fifo_fsm pops on the rising edge where rd_en=1 and empty=0. fifo_data is valid from that edge until the next pop.
- States: IDLE, REQ, CAPT, HOLD. All outputs are registered or Moore-decoded from state.
- IDLE: if drain_en=1 and fifo_empty=0 at the edge, go to REQ. Otherwise stay.
- REQ: fifo_rd_en=1 for exactly this one cycle. At the next edge, go to CAPT unconditionally.
- CAPT: fifo_data is valid. At the edge, out_data<=fifo_data, out_valid<=1, go to HOLD.
- HOLD: out_valid=1 and out_data stays stable until accepted.
  - Acceptance is an edge with out_ready=1.
  - On acceptance: word_count increments by 1.
  - If drain_en=1 and fifo_empty=0, go directly to REQ. out_valid drops to 0 for the REQ and CAPT cycles.
  - Otherwise go to IDLE with out_valid=0.
- Latency: edge E0 in IDLE sees non-empty. fifo_rd_en is high during cycle E0..E1. out_valid rises at E2. Best throughput is one word per 3 cycles.
- fifo_rd_en is never asserted outside REQ. It is never asserted twice for one word.
- drain_en dropping in REQ, CAPT or HOLD does not abort. The word completes delivery, then the FSM parks in IDLE.
- out_ready while out_valid=0 is ignored.
- word_count wraps modulo 2^CNT_WIDTH: 0xFFFF+1 becomes 0x0000 with no flag.
- fifo_empty is sampled only in IDLE and at HOLD acceptance. A stale empty=0 seen during the FIFO's own 1-cycle flag lag is the FIFO's responsibility.

Optional Feature:
FIFO_DRAIN_PARITY_EN
- Defined: adds output out_parity (1 bit), the even parity (XOR reduction) of out_data. It is registered together with out_data in CAPT and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: hold reset=0 with fifo_empty=0 and drain_en=1 -> fifo_rd_en=0, out_valid=0, out_data=0x00, word_count=0, busy=0 throughout.
- Single word: write 0x24 into fifo_fsm, drain_en=1, out_ready=1 -> exactly one 1-cycle fifo_rd_en pulse; out_valid=1 with out_data=0x24 two edges after the pulse starts; word_count=1; returns to IDLE.
- Three words back-to-back: write 0x24, 0x81, 0x09, out_ready=1 -> delivered in order with 3-cycle spacing; exactly 3 rd_en pulses; word_count=3; FSM returns to IDLE once fifo_empty=1.
- Backpressure: out_ready=0 for 5 cycles while word 0x81 is in HOLD -> out_data stays 0x81, out_valid stays 1, no fifo_rd_en during the stall; accepted on the first edge with out_ready=1.
- drain_en gating: drain_en=0 with the FIFO non-empty -> no rd_en, busy=0. Dropping drain_en in CAPT -> that word is still delivered, then the FSM sits in IDLE.
- Reset mid-HOLD: assert reset=0 asynchronously with out_valid=1 -> out_valid and word_count drop to 0 immediately, without waiting for a clock edge. After release, the next FIFO word is read normally. With FIFO_DRAIN_PARITY_EN defined, out_parity=1 for 0x07 and 0 for 0x81.

Source files
------------

// File: rtl/fifo_drain_fsm.sv
// fifo_drain_fsm: read-side controller for the fifo_fsm buffer.
// Watches fifo_empty, issues one-cycle fifo_rd_en pulses, captures each
// popped word and holds it on a valid/ready interface until accepted.
// Optional feature macro: FIFO_DRAIN_PARITY_EN adds out_parity (XOR of
// out_data), registered with out_data.
//
// state | meaning
// IDLE  | nothing in flight; waits for drain_en=1 and a non-empty FIFO
// REQ   | fifo_rd_en high for this single cycle
// CAPT  | fifo_data valid; captured into out_data at the next edge
// HOLD  | out_valid=1, out_data stable until an edge with out_ready=1
module fifo_drain_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // State register and all outputs; outputs are loaded with the value
    // belonging to the state being entered, so every output is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            word_count <= '0;
            busy       <= 1'b0;
`ifdef FIFO_DRAIN_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (drain_en && !fifo_empty) begin
                        state      <= REQ;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                REQ: begin
                    // The FIFO pops on this edge; its data is valid in CAPT.
                    state      <= CAPT;
                    fifo_rd_en <= 1'b0;
                end
                CAPT: begin
                    state     <= HOLD;
                    out_data  <= fifo_data;
                    out_valid <= 1'b1;
`ifdef FIFO_DRAIN_PARITY_EN
                    out_parity <= ^fifo_data;
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        word_count <= word_count + CNT_ONE;
                        out_valid  <= 1'b0;
                        if (drain_en && !fifo_empty) begin
                            state      <= REQ;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    fifo_rd_en <= 1'b0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
